serial_subtractor32: RTL and testbench

//  Multi-cycle borrow-ripple subtractor: diff = a - b - bin, computed DIGIT_W bits per clock.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/digit_subtractor.sv | 25 ++
 rtl/serial_subtractor32.sv | 126 ++++++++++++
 tb/tb_serial_subtractor32.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the multi-cycle borrow-ripple subtractor.
package serial_sub_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sub_state_t;

    function automatic int unsigned n_digits(input int unsigned width, input int unsigned digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT_W-bit borrow-ripple subtraction stage: {bo, d} = x - y - bi.
module digit_subtractor #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo
);

    logic [DIGIT_W:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < DIGIT_W; i++) begin
            d[i]    = x[i] ^ y[i] ^ br[i];
            br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
        end
        bo = br[DIGIT_W];
    end

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor, diff = a - b - bin over N_DIGITS cycles with valid/ready handshakes.
// Optional signed-overflow output ovf is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor32
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N_DIGITS = n_digits(WIDTH, DIGIT_W);
    localparam int unsigned CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

    if (WIDTH % DIGIT_W != 0) begin : g_bad_digit_w
        $error("serial_subtractor32: WIDTH must be a multiple of DIGIT_W");
    end

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, a_next, b_next;
    logic             borrow_q;
    logic [DIGIT_W-1:0] dig_d;
    logic             dig_bo;
    logic             last;

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q, b_msb_q;
`endif

    digit_subtractor #(
        .DIGIT_W(DIGIT_W)
    ) u_digit (
        .x (a_q[DIGIT_W-1:0]),
        .y (b_q[DIGIT_W-1:0]),
        .bi(borrow_q),
        .d (dig_d),
        .bo(dig_bo)
    );

    // Result digits refill the top of the minuend register as it drains, so after the last
    // digit a_next holds the complete difference.
    if (DIGIT_W == WIDTH) begin : g_one_digit
        assign a_next = dig_d;
        assign b_next = '0;
    end else begin : g_multi_digit
        assign a_next = {dig_d, a_q[WIDTH-1:DIGIT_W]};
        assign b_next = {{DIGIT_W{1'b0}}, b_q[WIDTH-1:DIGIT_W]};
    end

    assign last      = (cnt_q == LAST);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_BUSY;
            S_BUSY:  if (last)      state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else if (state_q == S_IDLE && in_valid) begin
            cnt_q    <= '0;
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
`ifdef SUB_OVERFLOW_EN
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
`endif
        end else if (state_q == S_BUSY) begin
            a_q      <= a_next;
            b_q      <= b_next;
            borrow_q <= dig_bo;
            cnt_q    <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                diff <= a_next;
                bout <= dig_bo;
`ifdef SUB_OVERFLOW_EN
                // The final digit carries the result MSB.
                ovf  <= (a_msb_q ^ b_msb_q) & (dig_d[DIGIT_W-1] ^ a_msb_q);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Self-checking bench for serial_subtractor32 at default WIDTH=32, DIGIT_W=4.
// Checks ovf as well when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor32;

    localparam int LATENCY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
`ifdef SUB_OVERFLOW_EN
    logic        ovf;
`endif

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor32 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
        exp_t        e;
        logic [32:0] r;
        r    = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        e.d  = r[31:0];
        e.bo = r[32];
        e.ov = (ma[31] ^ mb[31]) & (e.d[31] ^ ma[31]);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle a result is presented it must match the oldest outstanding model entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check("model_diff", {32'd0, diff}, {32'd0, exp_q[0].d});
                check("model_bout", {63'd0, bout}, {63'd0, exp_q[0].bo});
`ifdef SUB_OVERFLOW_EN
                check("model_ovf", {63'd0, ovf}, {63'd0, exp_q[0].ov});
`endif
            end
        end
    end

    // Present operands at an IDLE cycle; afterwards drive junk with in_valid high through BUSY.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_v, tbin));
        @(posedge clk); #1;
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        a   = ~ta;
        b   = ta ^ tb_v;
        bin = ~tbin;
    endtask

    task automatic wait_result(input logic [31:0] ed, input logic eb, input logic eo);
        int k = 0;
        while (!out_valid && k < 3 * LATENCY) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check("latency", 64'(k), 64'(LATENCY));
        check("diff_lit", {32'd0, diff}, {32'd0, ed});
        check("bout_lit", {63'd0, bout}, {63'd0, eb});
`ifdef SUB_OVERFLOW_EN
        check("ovf_lit", {63'd0, ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) $display("note: unknown ovf literal");
`endif
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                          input logic [31:0] ed, input logic eb, input logic eo);
        start_op(ta, tb_v, tbin);
        wait_result(ed, eb, eo);
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_diff", {32'd0, diff}, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

        // Back-pressure: result held for 5 cycles while new operands wait on in_valid.
        start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
        wait_result(32'h4B4B_4B4B, 1'b0, 1'b1);
        a        = 32'h0000_0010;
        b        = 32'h0000_0001;
        bin      = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("bp_valid_drop", {63'd0, out_valid}, 64'd0);
        check("bp_idle_ready", {63'd0, in_ready}, 64'd1);
        exp_q.push_back(model(32'h0000_0010, 32'h0000_0001, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", {63'd0, in_ready}, 64'd0);
        wait_result(32'h0000_000E, 1'b0, 1'b0);
        release_result();

        // Reset during the third BUSY cycle aborts the operation.
        start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_diff", {32'd0, diff}, 64'd0);
        check("abort_bout", {63'd0, bout}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_idle", {63'd0, in_ready}, 64'd1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
